// File: rtl/ap_isa_pkg.sv
// Shared definitions for the instruction-fetch path: reader FSM states, ISA word layout, address stride.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ap_isa_pkg;

   // Instruction word layout: opcode | cam | operand-2 | mem
   localparam int OPCODE_WIDTH   = 4;
   localparam int CAM_WIDTH      = 8;
   localparam int OPRAND_2_WIDTH = 2;
   localparam int MEM_WIDTH      = 16;
   localparam int ISA_WORD_WIDTH = OPCODE_WIDTH + CAM_WIDTH + OPRAND_2_WIDTH + MEM_WIDTH;

   // One instruction per 64-bit DDR word
   localparam int ISA_ADDR_STRIDE = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_DATA  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } rd_state_t;

   // Burst length clamp: smaller of the outstanding count and the burst ceiling
   function automatic int unsigned len_min(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/isa_rd_parity.sv
// Even-parity check of one DDR beat's instruction field plus its parity bit.
// Latency: combinational.
// Backpressure: none.
module isa_rd_parity
   import ap_isa_pkg::*;
#(
   parameter int ISA_WIDTH = ISA_WORD_WIDTH
) (
   input  logic [ISA_WIDTH:0] word,
   output logic               par_err
);

   // Parity bit makes the total number of ones even; any odd result is a mismatch
   assign par_err = ^word;

endmodule

// File: rtl/isa_ddr_reader.sv
// Converts one cache refill (addr, len) into DDR read bursts of up to MAX_BURST beats; one instruction per beat.
// Latency: 1 cycle from ddr_rd_data_valid to rd_burst_data_valid; next burst command the cycle after a burst's last beat.
// Backpressure: none on the beat stream; command held until ddr_rd_ack. Optional parity via ISA_RD_PARITY_CHECK_EN.
module isa_ddr_reader
   import ap_isa_pkg::*;
#(
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int DDR_DATA_WIDTH = 64,
   parameter int ISA_WIDTH      = ISA_WORD_WIDTH,
   parameter int LEN_WIDTH      = 10,
   parameter int MAX_BURST      = 64,
   parameter int ADDR_STRIDE    = ISA_ADDR_STRIDE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ISA_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
   input  logic [LEN_WIDTH-1:0]      isa_read_len,
   output logic [ISA_WIDTH-1:0]      instruction_to_cache,
   output logic [LEN_WIDTH-1:0]      rd_cnt_isa,
   output logic                      rd_burst_data_valid,
   output logic                      ddr_rd_req,
   output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
   output logic [LEN_WIDTH-1:0]      ddr_rd_len,
   input  logic                      ddr_rd_ack,
   input  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data,
   input  logic                      ddr_rd_data_valid,
   output logic                      isa_rd_err
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   rd_state_t                 state_q, state_d;
   logic [DDR_ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]      remaining_q;
   logic [LEN_WIDTH-1:0]      burst_len_q;
   logic [LEN_WIDTH-1:0]      beat_cnt_q;
   logic [LEN_WIDTH-1:0]      cur_len;
   logic [LEN_WIDTH-1:0]      rem_after;
   logic                      start;
   logic                      cmd_ack;
   logic                      deliver;
   logic                      drain_beat;
   logic                      stray;
   logic                      burst_last;
   logic                      unused_hi;

   // Bits above the instruction field are only consumed when parity checking is built in
   assign unused_hi = ^ddr_rd_data[DDR_DATA_WIDTH-1:ISA_WIDTH];

   assign cur_len     = LEN_WIDTH'(len_min(32'(remaining_q), 32'(MAX_BURST)));
   assign rem_after   = remaining_q - burst_len_q;
   assign burst_last  = (beat_cnt_q == burst_len_q - LEN_ONE);
   assign ddr_rd_addr = addr_q;
   assign ddr_rd_len  = cur_len;

`ifdef ISA_RD_PARITY_CHECK_EN
   logic par_err;

   isa_rd_parity #(
      .ISA_WIDTH (ISA_WIDTH)
   ) u_parity (
      .word    (ddr_rd_data[ISA_WIDTH:0]),
      .par_err (par_err)
   );
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and per-cycle control strobes; a dropped request aborts, beats outside a burst are stray
   always_comb begin
      state_d    = state_q;
      ddr_rd_req = 1'b0;
      start      = 1'b0;
      cmd_ack    = 1'b0;
      deliver    = 1'b0;
      drain_beat = 1'b0;
      stray      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stray = ddr_rd_data_valid;
            if (ISA_read_req) begin
               start   = 1'b1;
               state_d = (isa_read_len == '0) ? ST_DONE : ST_CMD;
            end
         end
         ST_CMD: begin
            stray      = ddr_rd_data_valid;
            ddr_rd_req = 1'b1;
            if (ddr_rd_ack) begin
               // An acked burst must be consumed even if the request fell in the same cycle
               cmd_ack = 1'b1;
               state_d = ISA_read_req ? ST_DATA : ST_DRAIN;
            end else if (!ISA_read_req) begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (!ISA_read_req) begin
               state_d = ST_DRAIN;
               if (ddr_rd_data_valid) begin
                  drain_beat = 1'b1;
                  if (burst_last) state_d = ST_IDLE;
               end
            end else if (ddr_rd_data_valid) begin
               deliver = 1'b1;
               if (burst_last) state_d = (rem_after != '0) ? ST_CMD : ST_DONE;
            end
         end
         ST_DONE: begin
            stray = ddr_rd_data_valid;
            if (!ISA_read_req) state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (ddr_rd_data_valid) begin
               drain_beat = 1'b1;
               if (burst_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: request latch, burst bookkeeping, delivered instruction/count and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q               <= '0;
         remaining_q          <= '0;
         burst_len_q          <= '0;
         beat_cnt_q           <= '0;
         instruction_to_cache <= '0;
         rd_cnt_isa           <= '0;
         rd_burst_data_valid  <= 1'b0;
         isa_rd_err           <= 1'b0;
      end else begin
         rd_burst_data_valid <= deliver;
         if (start) begin
            addr_q      <= ISA_read_addr;
            remaining_q <= isa_read_len;
            rd_cnt_isa  <= '0;
            isa_rd_err  <= 1'b0;
         end
         if (cmd_ack) begin
            burst_len_q <= cur_len;
            beat_cnt_q  <= '0;
         end
         if (deliver || drain_beat) beat_cnt_q <= beat_cnt_q + LEN_ONE;
         if (deliver) begin
            instruction_to_cache <= ddr_rd_data[ISA_WIDTH-1:0];
            rd_cnt_isa           <= rd_cnt_isa + LEN_ONE;
            if (burst_last) begin
               addr_q      <= addr_q + DDR_ADDR_WIDTH'(burst_len_q) * DDR_ADDR_WIDTH'(ADDR_STRIDE);
               remaining_q <= rem_after;
            end
         end
`ifdef ISA_RD_PARITY_CHECK_EN
         if (deliver && par_err) isa_rd_err <= 1'b1;
`endif
         if (stray) isa_rd_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_isa_ddr_reader.sv
// Bench for isa_ddr_reader: DDR responder model feeds a scoreboard; per-scenario tasks check commands and counters.
// Latency: expects delivery one cycle after each accepted beat.
// Backpressure: responder acks after a random 0..n cycle delay and may insert idle beats.
module tb_isa_ddr_reader;

   localparam int AW = 28;
   localparam int DW = 64;
   localparam int IW = 30;
   localparam int LW = 10;

   typedef struct packed { logic [IW-1:0] ins; logic [LW-1:0] cnt; } exp_t;
   typedef struct packed { logic [AW-1:0] addr; logic [LW-1:0] len; } cmd_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          ISA_read_req;
   logic [AW-1:0] ISA_read_addr;
   logic [LW-1:0] isa_read_len;
   logic [IW-1:0] instruction_to_cache;
   logic [LW-1:0] rd_cnt_isa;
   logic          rd_burst_data_valid;
   logic          ddr_rd_req;
   logic [AW-1:0] ddr_rd_addr;
   logic [LW-1:0] ddr_rd_len;
   logic          ddr_rd_ack;
   logic [DW-1:0] ddr_rd_data;
   logic          ddr_rd_data_valid;
   logic          isa_rd_err;

   exp_t exp_q[$];
   cmd_t cmd_q[$];
   logic req_after_q[$];

   int            total = 0;
   int            bad = 0;
   int            pulse_cnt = 0;
   int            exp_cnt = 0;
   int            deliver_limit = 100000;
   int            beats_left = 0;
   int            corrupt_no = 0;
   logic          gap_mode = 1'b0;
   logic          stray_go = 1'b0;
   logic          check_next = 1'b0;
   logic          par_test = 1'b0;
   logic [AW-1:0] beat_addr = '0;

   isa_ddr_reader dut (
      .clk                  (clk),
      .rst                  (rst),
      .ISA_read_req         (ISA_read_req),
      .ISA_read_addr        (ISA_read_addr),
      .isa_read_len         (isa_read_len),
      .instruction_to_cache (instruction_to_cache),
      .rd_cnt_isa           (rd_cnt_isa),
      .rd_burst_data_valid  (rd_burst_data_valid),
      .ddr_rd_req           (ddr_rd_req),
      .ddr_rd_addr          (ddr_rd_addr),
      .ddr_rd_len           (ddr_rd_len),
      .ddr_rd_ack           (ddr_rd_ack),
      .ddr_rd_data          (ddr_rd_data),
      .ddr_rd_data_valid    (ddr_rd_data_valid),
      .isa_rd_err           (isa_rd_err)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [IW-1:0] mk_ins(input logic [AW-1:0] a);
      return {2'b01, a} ^ 30'h155A_3C3C;
   endfunction

   // Word layout: junk | parity | instruction; parity is even over instruction+parity
   function automatic logic [DW-1:0] mk_word(input logic [AW-1:0] a, input logic flip);
      logic [IW-1:0] ins;
      ins = mk_ins(a);
      return {3'b101, 2'b00, a, (^ins) ^ flip, ins};
   endfunction

   // DDR responder: acks commands, streams beats, pushes expected deliveries
   initial begin
      logic flip;
      ddr_rd_ack        = 1'b0;
      ddr_rd_data_valid = 1'b0;
      ddr_rd_data       = '0;
      forever begin
         @(negedge clk);
         ddr_rd_ack        = 1'b0;
         ddr_rd_data_valid = 1'b0;
         if (check_next) begin
            req_after_q.push_back(ddr_rd_req);
            check_next = 1'b0;
         end
         if (stray_go) begin
            ddr_rd_data       = mk_word(28'h0, 1'b0);
            ddr_rd_data_valid = 1'b1;
            stray_go          = 1'b0;
         end else if (beats_left > 0) begin
            if (!(gap_mode && $urandom_range(0, 3) == 0)) begin
               flip = 1'b0;
               if (ISA_read_req && exp_cnt < deliver_limit) begin
                  exp_cnt++;
                  exp_q.push_back('{ins: mk_ins(beat_addr), cnt: LW'(exp_cnt)});
                  flip = (exp_cnt == corrupt_no);
               end
               ddr_rd_data       = mk_word(beat_addr, flip);
               ddr_rd_data_valid = 1'b1;
               beat_addr         = beat_addr + 28'd8;
               beats_left--;
               if (beats_left == 0) check_next = 1'b1;
            end
         end else if (ddr_rd_req && $urandom_range(0, 2) != 0) begin
            ddr_rd_ack = 1'b1;
            cmd_q.push_back('{addr: ddr_rd_addr, len: ddr_rd_len});
            beats_left = int'(ddr_rd_len);
            beat_addr  = ddr_rd_addr;
         end
      end
   end

   // Scoreboard: every delivery pulse must match the oldest expected instruction and count
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rd_burst_data_valid === 1'b1) begin
            pulse_cnt++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL pulse_unexpected: got ins=%h cnt=%0d, expected no pulse", instruction_to_cache, rd_cnt_isa);
            end else begin
               e = exp_q.pop_front();
               if ({instruction_to_cache, rd_cnt_isa} !== {e.ins, e.cnt}) begin
                  bad++;
                  $display("FAIL pulse_data: got ins=%h cnt=%0d, expected ins=%h cnt=%0d",
                           instruction_to_cache, rd_cnt_isa, e.ins, e.cnt);
               end
               if (par_test && (e.cnt == 10'd2 || e.cnt == 10'd3)) begin
                  total++;
                  if (isa_rd_err !== (e.cnt == 10'd3)) begin
                     bad++;
                     $display("FAIL parity_err_at_beat%0d: got %b, expected %b", e.cnt, isa_rd_err, e.cnt == 10'd3);
                  end
               end
            end
         end
      end
   end

   task automatic start_req(input logic [AW-1:0] a, input int n, input int limit);
      @(negedge clk);
      #1;
      exp_cnt       = 0;
      pulse_cnt     = 0;
      deliver_limit = limit;
      cmd_q.delete();
      req_after_q.delete();
      exp_q.delete();
      ISA_read_addr = a;
      isa_read_len  = LW'(n);
      ISA_read_req  = 1'b1;
   endtask

   task automatic end_req();
      @(negedge clk);
      #1;
      ISA_read_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({instruction_to_cache, rd_cnt_isa, rd_burst_data_valid, isa_rd_err} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got ins=%h cnt=%0d vld=%b err=%b, expected all 0",
                  instruction_to_cache, rd_cnt_isa, rd_burst_data_valid, isa_rd_err);
      end
      total++;
      if ({ddr_rd_req, ddr_rd_addr, ddr_rd_len} !== '0) begin
         bad++;
         $display("FAIL reset_ddr_cmd: got req=%b addr=%h len=%0d, expected 0", ddr_rd_req, ddr_rd_addr, ddr_rd_len);
      end
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single();
      int cyc = 0;
      start_req(28'h80, 10, 100000);
      while (rd_cnt_isa !== 10'd10 && cyc < 500) begin @(negedge clk); cyc++; end
      total++;
      if (cyc >= 500) begin bad++; $display("FAIL single_timeout: rd_cnt=%0d, expected 10", rd_cnt_isa); end
      repeat (6) @(negedge clk);
      total++;
      if (cmd_q.size() != 1 || cmd_q[0].addr !== 28'h80 || cmd_q[0].len !== 10'd10) begin
         bad++;
         $display("FAIL single_cmd: got %0d cmds first addr=%h len=%0d, expected 1 cmd addr=80 len=10",
                  cmd_q.size(), cmd_q.size() > 0 ? cmd_q[0].addr : '0, cmd_q.size() > 0 ? cmd_q[0].len : '0);
      end
      total++;
      if (rd_cnt_isa !== 10'd10 || ddr_rd_req !== 1'b0) begin
         bad++;
         $display("FAIL single_done_hold: got cnt=%0d req=%b, expected cnt=10 req=0", rd_cnt_isa, ddr_rd_req);
      end
      total++;
      if (pulse_cnt != 10 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL single_pulses: got %0d pulses, %0d pending, expected 10 and 0", pulse_cnt, exp_q.size());
      end
      total++;
      if (req_after_q.size() != 1 || req_after_q[0] !== 1'b0) begin
         bad++;
         $display("FAIL single_no_more_cmd: got %0d samples, expected one sample of req=0", req_after_q.size());
      end
      end_req();
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      gap_mode = 1'b1;
      start_req(28'h0, 128, 100000);
      while (rd_cnt_isa !== 10'd128 && cyc < 3000) begin @(negedge clk); cyc++; end
      total++;
      if (cyc >= 3000) begin bad++; $display("FAIL b2b_timeout: rd_cnt=%0d, expected 128", rd_cnt_isa); end
      repeat (6) @(negedge clk);
      total++;
      if (cmd_q.size() != 2 || cmd_q[0] !== {28'h0, 10'd64} || cmd_q[1] !== {28'h200, 10'd64}) begin
         bad++;
         $display("FAIL b2b_cmds: got %0d cmds, expected (000,64) then (200,64)", cmd_q.size());
      end
      total++;
      if (req_after_q.size() != 2 || req_after_q[0] !== 1'b1 || req_after_q[1] !== 1'b0) begin
         bad++;
         $display("FAIL b2b_gap: got %0d samples, expected req=1 after burst 1 and req=0 after burst 2", req_after_q.size());
      end
      total++;
      if (pulse_cnt != 128 || rd_cnt_isa !== 10'd128) begin
         bad++;
         $display("FAIL b2b_count: got pulses=%0d cnt=%0d, expected 128", pulse_cnt, rd_cnt_isa);
      end
      gap_mode = 1'b0;
      end_req();
   endtask

   task automatic test_zero_len();
      start_req(28'h400, 0, 100000);
      repeat (10) @(negedge clk);
      total++;
      if (cmd_q.size() != 0 || ddr_rd_req !== 1'b0) begin
         bad++;
         $display("FAIL zero_no_cmd: got %0d cmds req=%b, expected 0 cmds req=0", cmd_q.size(), ddr_rd_req);
      end
      total++;
      if (rd_cnt_isa !== 10'd0 || pulse_cnt != 0) begin
         bad++;
         $display("FAIL zero_count: got cnt=%0d pulses=%0d, expected 0 and 0", rd_cnt_isa, pulse_cnt);
      end
      end_req();
   endtask

   task automatic test_abort();
      int cyc = 0;
      start_req(28'h1000, 64, 5);
      while (rd_cnt_isa !== 10'd5 && cyc < 500) begin @(negedge clk); cyc++; end
      #1;
      ISA_read_req = 1'b0;
      total++;
      if (cyc >= 500) begin bad++; $display("FAIL abort_timeout: rd_cnt=%0d, expected 5", rd_cnt_isa); end
      cyc = 0;
      while (beats_left != 0 && cyc < 500) begin @(negedge clk); cyc++; end
      repeat (5) @(negedge clk);
      total++;
      if (rd_cnt_isa !== 10'd5 || pulse_cnt != 5) begin
         bad++;
         $display("FAIL abort_freeze: got cnt=%0d pulses=%0d, expected 5 and 5", rd_cnt_isa, pulse_cnt);
      end
      total++;
      if (isa_rd_err !== 1'b0 || ddr_rd_req !== 1'b0) begin
         bad++;
         $display("FAIL abort_drain: got err=%b req=%b, expected err=0 req=0", isa_rd_err, ddr_rd_req);
      end
      total++;
      if (cmd_q.size() != 1 || cmd_q[0] !== {28'h1000, 10'd64}) begin
         bad++;
         $display("FAIL abort_cmd: got %0d cmds, expected one (1000,64)", cmd_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_stray();
      int cyc = 0;
      @(negedge clk);
      #1;
      stray_go = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (isa_rd_err !== 1'b1) begin bad++; $display("FAIL stray_set: got err=%b, expected 1", isa_rd_err); end
      start_req(28'h40, 2, 100000);
      @(negedge clk);
      total++;
      if (isa_rd_err !== 1'b0) begin bad++; $display("FAIL stray_clear: got err=%b, expected 0", isa_rd_err); end
      while (rd_cnt_isa !== 10'd2 && cyc < 500) begin @(negedge clk); cyc++; end
      total++;
      if (cyc >= 500 || isa_rd_err !== 1'b0) begin
         bad++;
         $display("FAIL stray_followup: got cnt=%0d err=%b, expected cnt=2 err=0", rd_cnt_isa, isa_rd_err);
      end
      repeat (3) @(negedge clk);
      end_req();
   endtask

   task automatic test_wrap();
      int cyc = 0;
      start_req(28'hFFFFF00, 72, 100000);
      while (rd_cnt_isa !== 10'd72 && cyc < 2000) begin @(negedge clk); cyc++; end
      total++;
      if (cyc >= 2000) begin bad++; $display("FAIL wrap_timeout: rd_cnt=%0d, expected 72", rd_cnt_isa); end
      repeat (6) @(negedge clk);
      total++;
      if (cmd_q.size() != 2 || cmd_q[0] !== {28'hFFFFF00, 10'd64} || cmd_q[1] !== {28'h0000100, 10'd8}) begin
         bad++;
         $display("FAIL wrap_cmds: got %0d cmds, expected (FFFFF00,64) then (0000100,8)", cmd_q.size());
      end
      end_req();
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      start_req(28'h2000, 20, 3);
      while (rd_cnt_isa !== 10'd3 && cyc < 500) begin @(negedge clk); cyc++; end
      #1;
      rst          = 1'b1;
      ISA_read_req = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      total++;
      if (cyc >= 500 || rd_cnt_isa !== 10'd0 || ddr_rd_req !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_state: got cnt=%0d req=%b, expected cnt=0 req=0", rd_cnt_isa, ddr_rd_req);
      end
      cyc = 0;
      while (beats_left != 0 && cyc < 500) begin @(negedge clk); cyc++; end
      repeat (3) @(negedge clk);
      total++;
      if (isa_rd_err !== 1'b1 || pulse_cnt != 3) begin
         bad++;
         $display("FAIL rstmid_stray: got err=%b pulses=%0d, expected err=1 pulses=3", isa_rd_err, pulse_cnt);
      end
   endtask

`ifdef ISA_RD_PARITY_CHECK_EN
   task automatic test_parity();
      int cyc = 0;
      par_test   = 1'b1;
      corrupt_no = 3;
      start_req(28'h300, 10, 100000);
      while (rd_cnt_isa !== 10'd10 && cyc < 500) begin @(negedge clk); cyc++; end
      repeat (3) @(negedge clk);
      total++;
      if (cyc >= 500 || isa_rd_err !== 1'b1 || pulse_cnt != 10) begin
         bad++;
         $display("FAIL parity_final: got cnt=%0d err=%b pulses=%0d, expected 10, 1, 10", rd_cnt_isa, isa_rd_err, pulse_cnt);
      end
      par_test   = 1'b0;
      corrupt_no = 0;
      end_req();
   endtask
`endif

   initial begin
      rst           = 1'b1;
      ISA_read_req  = 1'b0;
      ISA_read_addr = '0;
      isa_read_len  = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_zero_len();
      test_abort();
      test_stray();
      test_wrap();
`ifdef ISA_RD_PARITY_CHECK_EN
      test_parity();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
